// File: rtl/gpio_bank_pkg.sv
// Shared register map and helpers for the multi-port Wishbone GPIO bank.
package gpio_bank_pkg;

  localparam int unsigned REG_W = 3;

  localparam logic [REG_W-1:0] REG_IN      = 3'd0;
  localparam logic [REG_W-1:0] REG_OUT     = 3'd1;
  localparam logic [REG_W-1:0] REG_OE      = 3'd2;
  localparam logic [REG_W-1:0] REG_RISE_EN = 3'd3;
  localparam logic [REG_W-1:0] REG_FALL_EN = 3'd4;
  localparam logic [REG_W-1:0] REG_STATUS  = 3'd5;

  // Expand Wishbone byte selects into a 32-bit write mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) m[b*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_bank_port.sv
// One GPIO port: input synchroniser, edge detect, control/status registers
// and the register read mux.
module gpio_bank_port
  import gpio_bank_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins,
  input  logic             wr,
  input  logic [REG_W-1:0] reg_sel,
  input  logic [31:0]      wdat,
  input  logic [3:0]       sel,
  output logic [31:0]      rd_c,
  output logic [WIDTH-1:0] gpio,
  output logic [WIDTH-1:0] gpio_oe,
  output logic [WIDTH-1:0] status
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] in_c;
  logic [WIDTH-1:0] wmask_c;
  logic [WIDTH-1:0] wdata_c;
  logic [WIDTH-1:0] set_c;
  logic [WIDTH-1:0] clr_c;

  assign in_c    = sync_q[SYNC_STAGES-1];
  assign wmask_c = WIDTH'(lane_mask(sel));
  assign wdata_c = WIDTH'(wdat);
  assign set_c   = (in_c & ~prev_q & rise_en_q) | (~in_c & prev_q & fall_en_q);
  assign clr_c   = (wr && reg_sel == REG_STATUS) ? (wdata_c & wmask_c) : '0;

  // Sticky status: an edge arriving with a W1C in the same cycle keeps the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      prev_q    <= '0;
      gpio      <= '0;
      gpio_oe   <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status    <= '0;
    end else begin
      sync_q[0] <= pins;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      prev_q <= in_c;
      status <= (status & ~clr_c) | set_c;
      if (wr) begin
        case (reg_sel)
          REG_OUT:     gpio      <= (gpio & ~wmask_c) | (wdata_c & wmask_c);
          REG_OE:      gpio_oe   <= (gpio_oe & ~wmask_c) | (wdata_c & wmask_c);
          REG_RISE_EN: rise_en_q <= (rise_en_q & ~wmask_c) | (wdata_c & wmask_c);
          REG_FALL_EN: fall_en_q <= (fall_en_q & ~wmask_c) | (wdata_c & wmask_c);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_c = '0;
    case (reg_sel)
      REG_IN:      rd_c = 32'(in_c);
      REG_OUT:     rd_c = 32'(gpio);
      REG_OE:      rd_c = 32'(gpio_oe);
      REG_RISE_EN: rd_c = 32'(rise_en_q);
      REG_FALL_EN: rd_c = 32'(fall_en_q);
      REG_STATUS:  rd_c = 32'(status);
      default: ;
    endcase
  end

endmodule

// File: rtl/gpio_bank_wb.sv
// Wishbone slave wrapping PORTS GPIO ports: address decode, single-cycle ack,
// registered read data and the aggregated interrupt.
module gpio_bank_wb
  import gpio_bank_pkg::*;
#(
  parameter int unsigned PORTS       = 2,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AW          = $clog2(PORTS) + 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [AW-1:0]          i_wb_adr,
  input  logic [31:0]            i_wb_dat,
  input  logic [3:0]             i_wb_sel,
  input  logic                   i_wb_we,
  input  logic                   i_wb_cyc,
  input  logic                   i_wb_stb,
  output logic [31:0]            o_wb_rdt,
  output logic                   o_wb_ack,
  input  logic [PORTS*WIDTH-1:0] i_gpio,
  output logic [PORTS*WIDTH-1:0] o_gpio,
  output logic [PORTS*WIDTH-1:0] o_gpio_oe,
  output logic                   o_irq
);

  localparam int unsigned NB = PORTS * WIDTH;

  logic             access_c;
  logic [31:0]      port_idx_c;
  logic [REG_W-1:0] reg_sel_c;
  logic [31:0]      rd_c;
  logic [31:0]      port_rd [PORTS];
  logic [NB-1:0]    status_all;

  assign access_c   = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  // Out-of-range port indices match no instance, so they read 0 and write nothing.
  assign port_idx_c = 32'(i_wb_adr >> 3);
  assign reg_sel_c  = i_wb_adr[REG_W-1:0];

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    gpio_bank_port #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_port (
      .clk    (i_clk),
      .rst    (i_rst),
      .pins   (i_gpio[p*WIDTH +: WIDTH]),
      .wr     (access_c & i_wb_we & (port_idx_c == 32'(p))),
      .reg_sel(reg_sel_c),
      .wdat   (i_wb_dat),
      .sel    (i_wb_sel),
      .rd_c   (port_rd[p]),
      .gpio   (o_gpio[p*WIDTH +: WIDTH]),
      .gpio_oe(o_gpio_oe[p*WIDTH +: WIDTH]),
      .status (status_all[p*WIDTH +: WIDTH])
    );
  end

  always_comb begin
    rd_c = '0;
    for (int p = 0; p < int'(PORTS); p++) begin
      if (port_idx_c == 32'(p)) rd_c = port_rd[p];
    end
  end

  // Ack and read data share one register stage; reset drops any pending ack.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
    end else begin
      o_wb_ack <= access_c;
      o_wb_rdt <= (access_c && !i_wb_we) ? rd_c : '0;
    end
  end

  assign o_irq = |status_all;

endmodule

// File: tb/tb_gpio_bank_wb.sv
// Self-checking bench for gpio_bank_wb: per-cycle behavioural model plus
// directed literal checks and a randomized bus/pin phase.
module tb_gpio_bank_wb;

  localparam int unsigned P  = 3;
  localparam int unsigned W  = 8;
  localparam int unsigned S  = 2;
  localparam int unsigned AW = $clog2(P) + 3;
  localparam int unsigned NB = P * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] wb_adr = '0;
  logic [31:0]   wb_dat = '0;
  logic [3:0]    wb_sel = '0;
  logic          wb_we = 1'b0;
  logic          wb_cyc = 1'b0;
  logic          wb_stb = 1'b0;
  logic [31:0]   wb_rdt;
  logic          wb_ack;
  logic [NB-1:0] gpio_in = '1;
  logic [NB-1:0] gpio_out;
  logic [NB-1:0] gpio_oe;
  logic          irq;

  int checks = 0;
  int errors = 0;

  gpio_bank_wb #(.PORTS(P), .WIDTH(W), .SYNC_STAGES(S)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_wb_adr (wb_adr),
    .i_wb_dat (wb_dat),
    .i_wb_sel (wb_sel),
    .i_wb_we  (wb_we),
    .i_wb_cyc (wb_cyc),
    .i_wb_stb (wb_stb),
    .o_wb_rdt (wb_rdt),
    .o_wb_ack (wb_ack),
    .i_gpio   (gpio_in),
    .o_gpio   (gpio_out),
    .o_gpio_oe(gpio_oe),
    .o_irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0]  m_out [P];
  logic [W-1:0]  m_oe  [P];
  logic [W-1:0]  m_ren [P];
  logic [W-1:0]  m_fen [P];
  logic [W-1:0]  m_sts [P];
  logic [NB-1:0] m_pin [S+1];   // m_pin[k] = pin value sampled k+1 edges ago
  logic          m_ack;
  logic [31:0]   m_rdt;

  function automatic logic [31:0] bytes_of(input logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < int'(P); p++) begin
      m_out[p] = '0; m_oe[p] = '0; m_ren[p] = '0; m_fen[p] = '0; m_sts[p] = '0;
    end
    for (int k = 0; k <= int'(S); k++) m_pin[k] = '0;
    m_ack = 1'b0;
    m_rdt = '0;
  endtask

  task automatic model_step();
    logic        acc;
    int          port;
    int          rg;
    logic [W-1:0] wm, wd, clr, setb, cur, prv;
    logic [31:0] lm;
    acc  = wb_cyc & wb_stb & ~m_ack;
    port = int'(wb_adr >> 3);
    rg   = int'(wb_adr[2:0]);
    lm   = bytes_of(wb_sel);
    wm   = lm[W-1:0];
    wd   = wb_dat[W-1:0];
    m_rdt = '0;
    if (acc && !wb_we && port < int'(P)) begin
      case (rg)
        0: m_rdt = 32'(m_pin[S-1][port*W +: W]);
        1: m_rdt = 32'(m_out[port]);
        2: m_rdt = 32'(m_oe[port]);
        3: m_rdt = 32'(m_ren[port]);
        4: m_rdt = 32'(m_fen[port]);
        5: m_rdt = 32'(m_sts[port]);
        default: m_rdt = '0;
      endcase
    end
    for (int p = 0; p < int'(P); p++) begin
      cur  = m_pin[S-1][p*W +: W];
      prv  = m_pin[S][p*W +: W];
      setb = (cur & ~prv & m_ren[p]) | (~cur & prv & m_fen[p]);
      clr  = '0;
      if (acc && wb_we && port == p) begin
        case (rg)
          1: m_out[p] = (m_out[p] & ~wm) | (wd & wm);
          2: m_oe[p]  = (m_oe[p]  & ~wm) | (wd & wm);
          3: m_ren[p] = (m_ren[p] & ~wm) | (wd & wm);
          4: m_fen[p] = (m_fen[p] & ~wm) | (wd & wm);
          5: clr = wd & wm;
          default: ;
        endcase
      end
      m_sts[p] = (m_sts[p] & ~clr) | setb;
    end
    for (int k = int'(S); k > 0; k--) m_pin[k] = m_pin[k-1];
    m_pin[0] = gpio_in;
    m_ack = acc;
  endtask

  task automatic model_compare();
    logic [NB-1:0] eo, eoe;
    logic          ei;
    ei = 1'b0;
    for (int p = 0; p < int'(P); p++) begin
      eo[p*W +: W]  = m_out[p];
      eoe[p*W +: W] = m_oe[p];
      ei = ei | (|m_sts[p]);
    end
    chk("model_ack", 64'(wb_ack), 64'(m_ack));
    chk("model_rdt", 64'(wb_rdt), 64'(m_rdt));
    chk("model_gpio", 64'(gpio_out), 64'(eo));
    chk("model_oe", 64'(gpio_oe), 64'(eoe));
    chk("model_irq", 64'(irq), 64'(ei));
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
    #1;
    model_compare();
  end

  // ---------------- directed helpers ----------------
  logic [NB-1:0] gpio_at_ack;
  logic [NB-1:0] oe_at_ack;

  task automatic bus_access(input int port, input int rg, input logic we,
                            input logic [31:0] dat, input logic [3:0] sel,
                            output logic [31:0] rd);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_adr = AW'(port*8 + rg); wb_dat = dat; wb_sel = sel;
    @(negedge clk);
    chk("ack_pulse", 64'(wb_ack), 64'h1);
    rd = wb_rdt;
    gpio_at_ack = gpio_out;
    oe_at_ack   = gpio_oe;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    chk("ack_single", 64'(wb_ack), 64'h0);
  endtask

  logic [31:0] rd;

  initial begin
    // Reset with all pins high
    repeat (10) begin
      @(negedge clk);
      chk("rst_gpio", 64'(gpio_out), 64'h0);
      chk("rst_oe", 64'(gpio_oe), 64'h0);
      chk("rst_irq", 64'(irq), 64'h0);
      chk("rst_ack", 64'(wb_ack), 64'h0);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_irq_pins_high", 64'(irq), 64'h0);
    bus_access(0, 0, 1'b0, 32'h0, 4'hF, rd);
    chk("in_port0", 64'(rd), 64'hFF);

    // OUT/OE on port 1
    bus_access(1, 1, 1'b1, 32'hFFFF_FF5A, 4'b0001, rd);
    chk("out_at_ack", 64'(gpio_at_ack[15:8]), 64'h5A);
    bus_access(1, 2, 1'b1, 32'h0000_00F0, 4'b0001, rd);
    chk("oe_at_ack", 64'(oe_at_ack[15:8]), 64'hF0);
    bus_access(1, 1, 1'b0, 32'h0, 4'hF, rd);
    chk("out_readback", 64'(rd), 64'h5A);
    bus_access(1, 2, 1'b0, 32'h0, 4'hF, rd);
    chk("oe_readback", 64'(rd), 64'hF0);

    // Rising-edge interrupt latency
    gpio_in = '0;
    repeat (4) @(negedge clk);
    bus_access(0, 3, 1'b1, 32'h1, 4'b0001, rd);
    gpio_in[0] = 1'b1;
    @(negedge clk); chk("irq_edge0", 64'(irq), 64'h0);
    @(negedge clk); chk("irq_edge1", 64'(irq), 64'h0);
    @(negedge clk); chk("irq_edge2", 64'(irq), 64'h1);
    bus_access(0, 5, 1'b0, 32'h0, 4'hF, rd);
    chk("status_rise", 64'(rd), 64'h01);
    gpio_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    bus_access(0, 5, 1'b0, 32'h0, 4'hF, rd);
    chk("status_fall_ignored", 64'(rd), 64'h01);

    // W1C colliding with a new enabled edge: set wins
    gpio_in[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_adr = AW'(5); wb_dat = 32'h1; wb_sel = 4'b0001;
    @(negedge clk);
    chk("collide_ack", 64'(wb_ack), 64'h1);
    chk("collide_irq", 64'(irq), 64'h1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    bus_access(0, 5, 1'b0, 32'h0, 4'hF, rd);
    chk("collide_status", 64'(rd), 64'h01);
    bus_access(0, 5, 1'b1, 32'h1, 4'b0001, rd);
    chk("w1c_irq", 64'(irq), 64'h0);
    bus_access(0, 5, 1'b0, 32'h0, 4'hF, rd);
    chk("w1c_status", 64'(rd), 64'h00);

    // Reserved offset and out-of-range port
    bus_access(1, 6, 1'b0, 32'h0, 4'hF, rd);
    chk("rsvd_read", 64'(rd), 64'h0);
    bus_access(int'(P), 1, 1'b0, 32'h0, 4'hF, rd);
    chk("oor_read", 64'(rd), 64'h0);
    bus_access(int'(P), 1, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
    bus_access(1, 7, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
    chk("oor_gpio", 64'(gpio_out), 64'h005A00);
    chk("oor_oe", 64'(gpio_oe), 64'h00F000);

    // Randomized bus traffic and pin activity
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      wb_cyc = ($urandom_range(0, 3) != 0);
      wb_stb = ($urandom_range(0, 2) != 0);
      wb_we  = 1'($urandom);
      wb_adr = AW'($urandom);
      wb_dat = $urandom;
      wb_sel = 4'($urandom);
      if ($urandom_range(0, 3) == 0) gpio_in = gpio_in ^ NB'($urandom & $urandom);
    end
    // Make sure status is set before the reset test
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    bus_access(2, 3, 1'b1, 32'hFF, 4'hF, rd);
    gpio_in[23:16] = ~gpio_in[23:16];
    repeat (4) @(negedge clk);
    chk("pre_reset_irq", 64'(irq), 64'h1);

    // Reset during a pending access
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = AW'(8 + 1); wb_sel = 4'hF;
    #2 rst = 1'b1;
    #1;
    chk("midrst_ack", 64'(wb_ack), 64'h0);
    chk("midrst_gpio", 64'(gpio_out), 64'h0);
    chk("midrst_oe", 64'(gpio_oe), 64'h0);
    chk("midrst_irq", 64'(irq), 64'h0);
    @(negedge clk);
    chk("midrst_noack", 64'(wb_ack), 64'h0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("postrst_ack", 64'(wb_ack), 64'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
